da2_spi: RTL
============

DA2_SPI -- requirements
Module: da2_spi

Interface
REQ-001 Parameter CLOCKS_PER_BIT, default 5: clk cycles per SCLK period (50 ns at 100 MHz).
REQ-002 Parameter CLOCKS_BEFORE_DATA, default 5: cycles with SYNC low before the first SCLK falling edge.
REQ-003 Parameter CLOCKS_AFTER_DATA, default 5: cycles with SYNC low after the last bit period.
REQ-004 Parameter CLOCKS_BETWEEN_TRANSACTIONS, default 10: minimum SYNC-high cycles between frames.
REQ-005 clk  input  1  system clock; all logic on the rising edge.
REQ-006 rst  input  1  synchronous reset, active-high.
REQ-007 s_valid  input  1  sample-pair offered.
REQ-008 s_ready  output  1  block can accept a sample-pair this cycle.
REQ-009 din0  input  12  channel 0 DAC code, unsigned.
REQ-010 din1  input  12  channel 1 DAC code, unsigned.
REQ-011 pd  input  2  power-down mode bits, shared by both channels.
REQ-012 sync  output  1  DAC frame select, active-low.
REQ-013 sclk  output  1  serial clock, idle high.
REQ-014 sdout0 / sdout1  output  1 each  serial data to DAC 0 / DAC 1.
REQ-015 busy  output  1  high in every state except S_IDLE.
REQ-016 done  output  1  one-cycle pulse when a frame's back porch ends.

Function
REQ-017 Transfer occurs on a cycle with s_valid=1 and s_ready=1; din0, din1 and pd are captured on that cycle only.
REQ-018 Frame per channel is 16 bits, MSB first: {2'b00, pd[1:0], dinN[11:0]}; both channels shift in lockstep.
REQ-019 States: S_IDLE, S_FRONT_PORCH, S_SHIFTING, S_BACK_PORCH, S_HOLD; count0 counts cycles within a state/bit; count1 counts bits 0..15.
REQ-020 S_IDLE: accept -> S_FRONT_PORCH next cycle with frame loaded; count0=0.
REQ-021 S_FRONT_PORCH: after CLOCKS_BEFORE_DATA cycles -> S_SHIFTING with count0=0 and count1=0.
REQ-022 S_SHIFTING: each bit lasts CLOCKS_PER_BIT cycles; after bit 15's last cycle -> S_BACK_PORCH.
REQ-023 S_BACK_PORCH: after CLOCKS_AFTER_DATA cycles -> S_HOLD; done=1 on the first S_HOLD cycle only.
REQ-024 S_HOLD: after CLOCKS_BETWEEN_TRANSACTIONS cycles -> next frame or S_IDLE (see REQ-033/034).
REQ-025 sync=1 only in S_IDLE and S_HOLD; sync=0 in the other states.
REQ-026 sclk=0 only in S_SHIFTING with count0 < CLOCKS_PER_BIT>>1; sclk=1 otherwise.
REQ-027 sdoutN = frame MSB; frame bit 15 is valid from the first S_FRONT_PORCH cycle.
REQ-028 Shift registers shift left, filling with 0, on the S_SHIFTING cycle where count0 == CLOCKS_PER_BIT>>1 (SCLK rising edge).
REQ-029 Each bit is therefore stable across its SCLK falling edge; exactly 16 falling edges occur per frame.
REQ-030 sdout0 = sdout1 = 0 outside S_FRONT_PORCH and S_SHIFTING.
REQ-031 Frame length with SYNC low = CLOCKS_BEFORE_DATA + 16*CLOCKS_PER_BIT + CLOCKS_AFTER_DATA cycles (90 at defaults).

Reset
REQ-032 rst=1 at any clock edge, including mid-frame, aborts the frame.
- Next cycle: state=S_IDLE; count0=count1=0; shift registers and holding buffer cleared.
- Outputs: sync=1, sclk=1, sdout0=sdout1=0, busy=0, done=0.
- s_ready is 1 on the first cycle after rst deasserts.

Configuration
REQ-033 With DA2_SPI_HOLD_BUF_EN defined:
- A one-entry holding buffer is present; s_ready = (state==S_IDLE) | !buf_full.
- A word accepted outside S_IDLE goes to the buffer.
- Final S_HOLD cycle with a full buffer or a same-cycle accept -> S_FRONT_PORCH, frame loaded from that word, buffer emptied.
REQ-034 Without DA2_SPI_HOLD_BUF_EN:
- No buffer; s_ready = (state==S_IDLE).
- S_HOLD always returns to S_IDLE, so back-to-back frames are separated by CLOCKS_BETWEEN_TRANSACTIONS+1 SYNC-high cycles.

Verification
REQ-035 Defaults, accept din0=12'hA5C, din1=12'h3F0, pd=2'b01:
- sync low for exactly 90 cycles starting the next cycle.
- DAC model captures 16'h1A5C and 16'h13F0 on SCLK falling edges.
- done pulses once; busy spans 100 cycles.
REQ-036 din0=12'hFFF, din1=12'h000, pd=2'b11: sdout0 frame 16'h3FFF, sdout1 frame 16'h3000; exactly 16 SCLK falls while sync low.
REQ-037 HOLD_BUF_EN, second word offered during S_SHIFTING:
- s_ready goes low after accept; second frame's sync falls exactly 10 cycles after first frame's sync rises.
- Without the macro: s_ready stays 0 until S_IDLE, gap is 11 cycles.
REQ-038 rst asserted at bit 7 of S_SHIFTING: next cycle sync=1, sclk=1, sdout=0, busy=0, s_ready=1; no done pulse.
REQ-039 s_valid held high continuously for 4 frames with HOLD_BUF_EN: 4 frames, 4 done pulses, every word delivered once in order, none dropped or duplicated.
REQ-040 CLOCKS_PER_BIT=4, CLOCKS_BEFORE_DATA=2: sync low for 2+64+5=71 cycles; sclk low 2, high 2 per bit.

Source files
------------

// File: rtl/da2_spi.sv
// da2_spi: drives two 12-bit DACs over a shared SYNC/SCLK pair with one data line each.
// Optional one-entry holding buffer for back-to-back frames: define DA2_SPI_HOLD_BUF_EN.
module da2_spi #(
  parameter int CLOCKS_PER_BIT              = 5,
  parameter int CLOCKS_BEFORE_DATA          = 5,
  parameter int CLOCKS_AFTER_DATA           = 5,
  parameter int CLOCKS_BETWEEN_TRANSACTIONS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [11:0] din0,
  input  logic [11:0] din1,
  input  logic [1:0]  pd,
  output logic        sync,
  output logic        sclk,
  output logic        sdout0,
  output logic        sdout1,
  output logic        busy,
  output logic        done
);

  localparam int M1 = (CLOCKS_PER_BIT > CLOCKS_BEFORE_DATA) ? CLOCKS_PER_BIT : CLOCKS_BEFORE_DATA;
  localparam int M2 = (M1 > CLOCKS_AFTER_DATA) ? M1 : CLOCKS_AFTER_DATA;
  localparam int M3 = (M2 > CLOCKS_BETWEEN_TRANSACTIONS) ? M2 : CLOCKS_BETWEEN_TRANSACTIONS;
  localparam int CW = (M3 < 2) ? 1 : $clog2(M3 + 1);
  localparam logic [CW-1:0] HALF = CW'(CLOCKS_PER_BIT >> 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FRONT_PORCH, S_SHIFTING, S_BACK_PORCH, S_HOLD
  } state_t;

  state_t        state;
  logic [CW-1:0] count0;
  logic [3:0]    count1;
  logic [15:0]   shift0;
  logic [15:0]   shift1;
  logic [15:0]   frame0;
  logic [15:0]   frame1;
  logic          accept;
  logic          hold_last;

  assign frame0    = {2'b00, pd, din0};
  assign frame1    = {2'b00, pd, din1};
  assign hold_last = (state == S_HOLD) && (count0 == CW'(CLOCKS_BETWEEN_TRANSACTIONS - 1));

`ifdef DA2_SPI_HOLD_BUF_EN
  logic [15:0] buf0;
  logic [15:0] buf1;
  logic        buf_full;
  assign s_ready = (state == S_IDLE) | ~buf_full;
`else
  assign s_ready = (state == S_IDLE);
`endif

  assign accept = s_valid & s_ready;

  // Line outputs are pure decodes of registered state, so no input reaches them combinationally.
  assign sync   = (state == S_IDLE) || (state == S_HOLD);
  assign sclk   = !((state == S_SHIFTING) && (count0 < HALF));
  assign sdout0 = ((state == S_FRONT_PORCH) || (state == S_SHIFTING)) & shift0[15];
  assign sdout1 = ((state == S_FRONT_PORCH) || (state == S_SHIFTING)) & shift1[15];
  assign busy   = (state != S_IDLE);

  // Frame sequencer: porch/bit timing, shift registers, done pulse and holding buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      count0 <= '0;
      count1 <= 4'd0;
      shift0 <= 16'h0000;
      shift1 <= 16'h0000;
      done   <= 1'b0;
`ifdef DA2_SPI_HOLD_BUF_EN
      buf0     <= 16'h0000;
      buf1     <= 16'h0000;
      buf_full <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            shift0 <= frame0;
            shift1 <= frame1;
            count0 <= '0;
            state  <= S_FRONT_PORCH;
          end
        end
        S_FRONT_PORCH: begin
          if (count0 == CW'(CLOCKS_BEFORE_DATA - 1)) begin
            count0 <= '0;
            count1 <= 4'd0;
            state  <= S_SHIFTING;
          end else begin
            count0 <= count0 + CW'(1);
          end
        end
        S_SHIFTING: begin
          // Advance data on the SCLK rising edge so it is stable across the next fall.
          if (count0 == HALF) begin
            shift0 <= {shift0[14:0], 1'b0};
            shift1 <= {shift1[14:0], 1'b0};
          end
          if (count0 == CW'(CLOCKS_PER_BIT - 1)) begin
            count0 <= '0;
            if (count1 == 4'd15) begin
              count1 <= 4'd0;
              state  <= S_BACK_PORCH;
            end else begin
              count1 <= count1 + 4'd1;
            end
          end else begin
            count0 <= count0 + CW'(1);
          end
        end
        S_BACK_PORCH: begin
          if (count0 == CW'(CLOCKS_AFTER_DATA - 1)) begin
            count0 <= '0;
            done   <= 1'b1;
            state  <= S_HOLD;
          end else begin
            count0 <= count0 + CW'(1);
          end
        end
        S_HOLD: begin
          if (hold_last) begin
            count0 <= '0;
`ifdef DA2_SPI_HOLD_BUF_EN
            if (buf_full) begin
              shift0   <= buf0;
              shift1   <= buf1;
              buf_full <= 1'b0;
              state    <= S_FRONT_PORCH;
            end else if (accept) begin
              shift0 <= frame0;
              shift1 <= frame1;
              state  <= S_FRONT_PORCH;
            end else begin
              state <= S_IDLE;
            end
`else
            state <= S_IDLE;
`endif
          end else begin
            count0 <= count0 + CW'(1);
          end
        end
        default: begin
          state  <= S_IDLE;
          count0 <= '0;
          count1 <= 4'd0;
        end
      endcase
`ifdef DA2_SPI_HOLD_BUF_EN
      // A word taken while busy parks here unless it starts a frame directly from S_HOLD.
      if (accept && (state != S_IDLE) && !hold_last) begin
        buf0     <= frame0;
        buf1     <= frame1;
        buf_full <= 1'b1;
      end
`endif
    end
  end

endmodule
